// File: rtl/nios_interrupt_nios_cpu_debug_cmd_sched_pkg.sv
// Shared definitions for the debug command scheduler: command codes and
// their arbitration order, scheduler state encodings, status bit indices,
// and the packed FIFO entry layout.
package nios_interrupt_nios_cpu_debug_pkg;

  localparam int JDO_W    = 38;
  localparam int NUM_CMDS = 6;
  localparam int ENTRY_W  = 3 + JDO_W;
  // jdo bit that requests a monitor operation on an ocimem_a command
  localparam int MON_REQ_BIT = 34;

  // Encoding doubles as arbitration priority: a lower code wins.
  typedef enum logic [2:0] {
    CMD_OCIMEM_A  = 3'd0,
    CMD_OCIMEM_B  = 3'd1,
    CMD_BREAK_A   = 3'd2,
    CMD_BREAK_B   = 3'd3,
    CMD_BREAK_C   = 3'd4,
    CMD_TRACECTRL = 3'd5
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_MON_START = 2'd2,
    ST_MON_WAIT  = 2'd3
  } sched_state_e;

  localparam int STAT_OVERFLOW  = 0;
  localparam int STAT_COLLISION = 1;
  localparam int STAT_MON_ERROR = 2;
  localparam int STAT_TIMEOUT   = 3;

  typedef struct packed {
    cmd_type_e         ctype;
    logic [JDO_W-1:0]  data;
  } cmd_entry_t;

  // Strobe vector is indexed by command code; the lowest set index wins.
  function automatic cmd_type_e prio_pick(input logic [NUM_CMDS-1:0] strobes);
    prio_pick = CMD_OCIMEM_A;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (strobes[i]) prio_pick = cmd_type_e'(i[2:0]);
    end
  endfunction

endpackage

// File: rtl/nios_interrupt_nios_cpu_debug_cmd_sched_if.sv
// Command bus between the scheduler and the downstream debug resource.
//   cmd_valid  command presented
//   cmd_type   command code
//   cmd_data   jdo word captured with the command
//   cmd_ready  downstream accepts when cmd_valid & cmd_ready
interface nios_interrupt_nios_cpu_debug_cmd_sched_if;
  import nios_interrupt_nios_cpu_debug_pkg::*;

  logic              cmd_valid;
  logic [2:0]        cmd_type;
  logic [JDO_W-1:0]  cmd_data;
  logic              cmd_ready;

  modport master (output cmd_valid, output cmd_type, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_type, input cmd_data, output cmd_ready);
endinterface

// File: rtl/nios_interrupt_nios_cpu_debug_cmd_sched_fifo.sv
// Command queue for the debug scheduler.
//   push/push_data  enqueue; accepted when not full, or when full with a
//                   same-cycle pop
//   pop             dequeue the head (ignored when empty)
//   head            entry at the read pointer
//   head_next       entry behind the head, so the scheduler can present the
//                   next command on the same edge that retires the current one
//   full/empty/count occupancy
module nios_interrupt_nios_cpu_debug_cmd_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [WIDTH-1:0]           head_next,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty      = (cnt == '0);
  assign full       = (cnt == (AW+1)'(DEPTH));
  assign count      = cnt;
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_inc = rd_ptr + AW'(1);
  assign head       = mem[rd_ptr];
  assign head_next  = mem[rd_ptr_inc];

  // Depth is a power of two, so pointer wrap is plain binary rollover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr_inc;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nios_interrupt_nios_cpu_debug_cmd_sched.sv
// Debug command scheduler: arbitrates the take_action_* strobes into a
// command queue, issues queued commands on the cmd bus, and optionally runs
// a monitor operation with a timeout after an ocimem_a command.
//   clk, reset_n                 clock, async active-low reset
//   jdo, take_action_*           debug-slave word and command strobes
//   cmd_bus (master)             cmd_valid/cmd_type/cmd_data out, cmd_ready in
//   monitor_go                   one-cycle monitor start pulse
//   monitor_ready/monitor_error  monitor completion and error
//   busy                         queue non-empty or scheduler active
//   status/status_clr            sticky {timeout, mon_error, collision, overflow}
//
// state        | meaning
// ST_IDLE      | nothing presented; load queue head when one exists
// ST_ISSUE     | command held on cmd bus until cmd_ready
// ST_MON_START | monitor_go pulse, timeout counter loaded
// ST_MON_WAIT  | waiting for monitor_ready or counter to run out
module nios_interrupt_nios_cpu_debug_cmd_sched
  import nios_interrupt_nios_cpu_debug_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int MON_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [JDO_W-1:0]         jdo,
  input  logic                     take_action_ocimem_a,
  input  logic                     take_action_ocimem_b,
  input  logic                     take_action_break_a,
  input  logic                     take_action_break_b,
  input  logic                     take_action_break_c,
  input  logic                     take_action_tracectrl,
  input  logic                     monitor_ready,
  input  logic                     monitor_error,
  input  logic                     status_clr,
  nios_interrupt_nios_cpu_debug_cmd_sched_if.master cmd_bus,
  output logic                     monitor_go,
  output logic                     busy,
  output logic [3:0]               status
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sched_state_e       state, state_nxt;
  logic               valid_q, valid_nxt;
  cmd_type_e          type_q, type_nxt;
  logic [JDO_W-1:0]   data_q, data_nxt;
  logic [7:0]         cnt_q, cnt_nxt;
  logic [3:0]         status_q, status_nxt;

  logic [NUM_CMDS-1:0] strobes;
  logic                any_strobe;
  logic                collision;
  logic                overflow;
  logic                set_mon_err;
  logic                set_timeout;
  logic                pop;
  cmd_entry_t          push_entry;
  cmd_entry_t          head, head_next;
  logic [ENTRY_W-1:0]  head_raw, head_next_raw;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;

  assign strobes = {take_action_tracectrl, take_action_break_c, take_action_break_b,
                    take_action_break_a, take_action_ocimem_b, take_action_ocimem_a};
  assign any_strobe = |strobes;
  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign collision  = (strobes & (strobes - 6'd1)) != 6'd0;
  assign overflow   = any_strobe && fifo_full && !pop;
  assign push_entry = '{ctype: prio_pick(strobes), data: jdo};
  assign head       = cmd_entry_t'(head_raw);
  assign head_next  = cmd_entry_t'(head_next_raw);

  nios_interrupt_nios_cpu_debug_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (any_strobe),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_raw),
    .head_next (head_next_raw),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      valid_q  <= 1'b0;
      type_q   <= CMD_OCIMEM_A;
      data_q   <= '0;
      cnt_q    <= '0;
      status_q <= '0;
    end else begin
      state    <= state_nxt;
      valid_q  <= valid_nxt;
      type_q   <= type_nxt;
      data_q   <= data_nxt;
      cnt_q    <= cnt_nxt;
      status_q <= status_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    valid_nxt   = valid_q;
    type_nxt    = type_q;
    data_nxt    = data_q;
    cnt_nxt     = cnt_q;
    pop         = 1'b0;
    monitor_go  = 1'b0;
    set_mon_err = 1'b0;
    set_timeout = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ST_ISSUE;
          valid_nxt = 1'b1;
          type_nxt  = head.ctype;
          data_nxt  = head.data;
        end
      end
      ST_ISSUE: begin
        if (cmd_bus.cmd_ready) begin
          pop = 1'b1;
          if (type_q == CMD_OCIMEM_A && data_q[MON_REQ_BIT]) begin
            state_nxt = ST_MON_START;
            valid_nxt = 1'b0;
          end else if (fifo_count > CW'(1)) begin
            // Entry behind the one being retired goes straight out.
            type_nxt = head_next.ctype;
            data_nxt = head_next.data;
          end else begin
            state_nxt = ST_IDLE;
            valid_nxt = 1'b0;
          end
        end
      end
      ST_MON_START: begin
        monitor_go = 1'b1;
        cnt_nxt    = 8'(MON_TIMEOUT);
        state_nxt  = ST_MON_WAIT;
      end
      ST_MON_WAIT: begin
        cnt_nxt = cnt_q - 8'd1;
        // Ready takes precedence over the counter running out.
        if (monitor_ready) begin
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
          set_mon_err = monitor_error;
        end else if (cnt_q <= 8'd1) begin
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
          set_timeout = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Clear first, then OR in this cycle's events so a set wins over clear.
    status_nxt = status_q & {4{~status_clr}};
    status_nxt[STAT_OVERFLOW]  = status_nxt[STAT_OVERFLOW]  | overflow;
    status_nxt[STAT_COLLISION] = status_nxt[STAT_COLLISION] | collision;
    status_nxt[STAT_MON_ERROR] = status_nxt[STAT_MON_ERROR] | set_mon_err;
    status_nxt[STAT_TIMEOUT]   = status_nxt[STAT_TIMEOUT]   | set_timeout;
  end

  assign cmd_bus.cmd_valid = valid_q;
  assign cmd_bus.cmd_type  = type_q;
  assign cmd_bus.cmd_data  = data_q;
  assign busy              = !fifo_empty || (state != ST_IDLE);
  assign status            = status_q;

endmodule

// File: tb/tb_nios_interrupt_nios_cpu_debug_cmd_sched.sv
module tb_nios_interrupt_nios_cpu_debug_cmd_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_action_break_a;
  logic        take_action_break_b, take_action_break_c, take_action_tracectrl;
  logic        monitor_ready, monitor_error, status_clr;
  logic        monitor_go, busy;
  logic [3:0]  status;

  int n_checks = 0;
  int n_errors = 0;

  nios_interrupt_nios_cpu_debug_cmd_sched_if cmd_bus();

  nios_interrupt_nios_cpu_debug_cmd_sched dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .jdo                   (jdo),
    .take_action_ocimem_a  (take_action_ocimem_a),
    .take_action_ocimem_b  (take_action_ocimem_b),
    .take_action_break_a   (take_action_break_a),
    .take_action_break_b   (take_action_break_b),
    .take_action_break_c   (take_action_break_c),
    .take_action_tracectrl (take_action_tracectrl),
    .monitor_ready         (monitor_ready),
    .monitor_error         (monitor_error),
    .status_clr            (status_clr),
    .cmd_bus               (cmd_bus),
    .monitor_go            (monitor_go),
    .busy                  (busy),
    .status                (status)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // s[0]=ocimem_a ... s[5]=tracectrl
  task automatic drive(input logic [5:0] s, input logic [37:0] d);
    {take_action_tracectrl, take_action_break_c, take_action_break_b,
     take_action_break_a, take_action_ocimem_b, take_action_ocimem_a} = s;
    jdo = d;
  endtask

  task automatic clear_status();
    @(negedge clk); status_clr = 1'b1;
    @(negedge clk); status_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int go_cnt, valid_seen, wait_cycles, to_seen, got;
    reset_n = 1'b0;
    drive(6'b0, 38'h0);
    cmd_bus.cmd_ready = 1'b1;
    monitor_ready = 1'b0;
    monitor_error = 1'b0;
    status_clr = 1'b0;

    #3;
    chk_eq("rst_valid", cmd_bus.cmd_valid, 0);
    chk_eq("rst_type", cmd_bus.cmd_type, 0);
    chk_eq("rst_data", cmd_bus.cmd_data, 0);
    chk_eq("rst_go", monitor_go, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_status", status, 0);
    repeat (2) @(negedge clk);

    // single break_b strobed in the first cycle out of reset
    @(negedge clk); reset_n = 1'b1; drive(6'b001000, 38'h15);
    @(negedge clk); drive(6'b0, 38'h0);
    chk_eq("bb_valid_early", cmd_bus.cmd_valid, 0);
    @(negedge clk);
    chk_eq("bb_valid", cmd_bus.cmd_valid, 1);
    chk_eq("bb_type", cmd_bus.cmd_type, 3);
    chk_eq("bb_data", cmd_bus.cmd_data, 38'h15);
    @(negedge clk);
    chk_eq("bb_valid_drop", cmd_bus.cmd_valid, 0);
    chk_eq("bb_busy", busy, 0);

    // ocimem_a + tracectrl collision
    @(negedge clk); drive(6'b100001, 38'h1);
    @(negedge clk); drive(6'b0, 38'h0);
    @(negedge clk);
    chk_eq("col_valid", cmd_bus.cmd_valid, 1);
    chk_eq("col_type", cmd_bus.cmd_type, 0);
    chk_eq("col_data", cmd_bus.cmd_data, 38'h1);
    chk_eq("col_status", status, 4'b0010);
    @(negedge clk);
    chk_eq("col_single", cmd_bus.cmd_valid, 0);
    chk_eq("col_busy", busy, 0);
    status_clr = 1'b1;
    @(negedge clk); status_clr = 1'b0;
    chk_eq("clr_status", status, 0);

    // clear coinciding with a collision: flag stays set
    @(negedge clk); status_clr = 1'b1; drive(6'b000011, 38'h3);
    @(negedge clk); status_clr = 1'b0; drive(6'b0, 38'h0);
    chk_eq("setwins_status", status, 4'b0010);
    @(negedge clk);
    chk_eq("setwins_type", cmd_bus.cmd_type, 0);
    chk_eq("setwins_data", cmd_bus.cmd_data, 38'h3);
    @(negedge clk);
    chk_eq("setwins_done", cmd_bus.cmd_valid, 0);
    clear_status();

    // five strobes into a depth-4 queue with the consumer stalled
    cmd_bus.cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(6'b000010 << i, 38'hA1 + 38'(i));
    end
    @(negedge clk); drive(6'b0, 38'h0);
    chk_eq("ovf_status", status, 4'b0001);
    chk_eq("ovf_hold_type", cmd_bus.cmd_type, 1);
    @(negedge clk);
    chk_eq("ovf_hold_valid", cmd_bus.cmd_valid, 1);
    cmd_bus.cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_eq($sformatf("ovf_valid%0d", k), cmd_bus.cmd_valid, 1);
      chk_eq($sformatf("ovf_type%0d", k), cmd_bus.cmd_type, 64'(k + 1));
      chk_eq($sformatf("ovf_data%0d", k), cmd_bus.cmd_data, 64'(38'hA1 + 38'(k)));
      @(negedge clk);
    end
    chk_eq("ovf_drained", cmd_bus.cmd_valid, 0);
    chk_eq("ovf_busy", busy, 0);
    clear_status();

    // push and pop together on a full queue
    cmd_bus.cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(6'b000100, 38'hB1 + 38'(i));
    end
    @(negedge clk); drive(6'b010000, 38'hB5); cmd_bus.cmd_ready = 1'b1;
    chk_eq("fullpp_head", cmd_bus.cmd_data, 38'hB1);
    @(negedge clk); drive(6'b0, 38'h0);
    chk_eq("fullpp_status", status, 0);
    for (int k = 0; k < 4; k++) begin
      chk_eq($sformatf("fullpp_type%0d", k), cmd_bus.cmd_type, (k < 3) ? 64'd2 : 64'd4);
      chk_eq($sformatf("fullpp_data%0d", k), cmd_bus.cmd_data, 64'(38'hB2 + 38'(k)));
      @(negedge clk);
    end
    chk_eq("fullpp_drained", cmd_bus.cmd_valid, 0);

    // monitor with error, ready 10 cycles after go
    @(negedge clk); drive(6'b000001, 38'h400000005);
    @(negedge clk); drive(6'b0, 38'h0);
    @(negedge clk);
    chk_eq("mon_valid", cmd_bus.cmd_valid, 1);
    chk_eq("mon_type", cmd_bus.cmd_type, 0);
    go_cnt = 0; valid_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (monitor_go) go_cnt++;
      if (i > 0 && cmd_bus.cmd_valid) valid_seen++;
      monitor_ready = (i == 10);
      monitor_error = (i == 10);
    end
    chk_eq("mon_go_pulses", go_cnt, 1);
    chk_eq("mon_valid_low", valid_seen, 0);
    chk_eq("mon_status", status, 4'b0100);
    chk_eq("mon_idle", busy, 0);
    clear_status();

    // monitor timeout, then a queued command issues
    @(negedge clk); drive(6'b000001, 38'h400000005);
    @(negedge clk); drive(6'b010000, 38'h2A);
    @(negedge clk); drive(6'b0, 38'h0);
    chk_eq("to_valid", cmd_bus.cmd_valid, 1);
    @(negedge clk);
    chk_eq("to_go", monitor_go, 1);
    wait_cycles = 0; to_seen = 0;
    for (int i = 0; i < 300 && to_seen == 0; i++) begin
      @(negedge clk);
      if (status[3]) to_seen = 1;
      else wait_cycles++;
    end
    chk_eq("to_seen", to_seen, 1);
    chk_eq("to_cycles", wait_cycles, 255);
    chk_eq("to_status", status, 4'b1000);
    got = 0;
    for (int i = 0; i < 5 && got == 0; i++) begin
      @(negedge clk);
      if (cmd_bus.cmd_valid) got = 1;
    end
    chk_eq("to_next_seen", got, 1);
    chk_eq("to_next_type", cmd_bus.cmd_type, 4);
    chk_eq("to_next_data", cmd_bus.cmd_data, 38'h2A);
    @(negedge clk);
    chk_eq("to_next_done", busy, 0);
    clear_status();

    // reset during MON_WAIT with two commands queued
    @(negedge clk); drive(6'b010001, 38'h400000005);
    @(negedge clk); drive(6'b000010, 38'h7);
    @(negedge clk); drive(6'b000100, 38'h8);
    chk_eq("rw_valid", cmd_bus.cmd_valid, 1);
    @(negedge clk); drive(6'b0, 38'h0);
    chk_eq("rw_go", monitor_go, 1);
    repeat (3) @(negedge clk);
    chk_eq("rw_busy_pre", busy, 1);
    chk_eq("rw_status_pre", status, 4'b0010);
    #2 reset_n = 1'b0;
    #1;
    chk_eq("rw_valid_rst", cmd_bus.cmd_valid, 0);
    chk_eq("rw_type_rst", cmd_bus.cmd_type, 0);
    chk_eq("rw_data_rst", cmd_bus.cmd_data, 0);
    chk_eq("rw_go_rst", monitor_go, 0);
    chk_eq("rw_busy_rst", busy, 0);
    chk_eq("rw_status_rst", status, 0);
    @(negedge clk); reset_n = 1'b1;
    valid_seen = 0; go_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_bus.cmd_valid) valid_seen++;
      if (monitor_go) go_cnt++;
    end
    chk_eq("rw_no_valid", valid_seen, 0);
    chk_eq("rw_no_go", go_cnt, 0);
    chk_eq("rw_busy_post", busy, 0);
    drive(6'b001000, 38'h9);
    @(negedge clk); drive(6'b0, 38'h0);
    @(negedge clk);
    chk_eq("rw_new_valid", cmd_bus.cmd_valid, 1);
    chk_eq("rw_new_type", cmd_bus.cmd_type, 3);
    chk_eq("rw_new_data", cmd_bus.cmd_data, 38'h9);
    @(negedge clk);
    chk_eq("rw_new_done", cmd_bus.cmd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
